// File: rtl/i2c_temp_responder_if.sv
// ---------------------------------------------------------------------------
// i2c_temp_responder_if
//   Pad-side I2C bus bundle for the temperature-sensor responder.
//   scl_in : raw SCL seen at the pad (asynchronous to the system clock)
//   sda_in : raw SDA seen at the pad (wired-AND of every open-drain driver)
//   sda_oe : 1 = target pulls SDA low, 0 = target releases SDA
//   Modport slave  : the responder (samples SCL/SDA, drives sda_oe).
//   Modport master : the bus side (drives SCL/SDA, observes sda_oe).
// ---------------------------------------------------------------------------
interface i2c_temp_responder_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe
    );

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe
    );
endinterface

// File: rtl/i2c_temp_responder.sv
// ---------------------------------------------------------------------------
// i2c_temp_responder
//   I2C target that stands in for the on-board temperature sensor. A read at
//   address ADDR returns a 16-bit temperature word MSB byte first, repeating
//   MSB,LSB,MSB,... while the master keeps ACKing. Written bytes are ACKed
//   and handed to local logic. SCL is never stretched.
//
//   Ports
//     clk_100MHz : system clock, all logic on the rising edge
//     rst_n      : asynchronous active-low reset
//     bus        : pad-side bus (scl_in, sda_in in; sda_oe out)
//     temp_in    : live temperature word, snapshotted at address match
//     wr_data    : last byte received in a write transfer
//     wr_valid   : 1-cycle pulse, wr_data valid
//     rd_done    : 1-cycle pulse when the master NACKs a read byte
//     busy       : high from address match until STOP/NACK/mismatch
// ---------------------------------------------------------------------------
module i2c_temp_responder #(
    parameter logic [6:0] ADDR     = 7'h4B,
    parameter int         SYNC_STG = 2
) (
    input  logic                    clk_100MHz,
    input  logic                    rst_n,
    i2c_temp_responder_if.slave     bus,
    input  logic [15:0]             temp_in,
    output logic [7:0]              wr_data,
    output logic                    wr_valid,
    output logic                    rd_done,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_TX,
        S_TX_ACK,
        S_RX,
        S_RX_ACK
    } state_t;

    // Synchronizers and edge-detect flops, preset to the idle-bus level
    logic [SYNC_STG-1:0] r_scl_sync;
    logic [SYNC_STG-1:0] r_sda_sync;
    logic                r_scl_d;
    logic                r_sda_d;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic        r_got8;      // eight data bits seen; next SCL fall ends the byte
    logic [7:0]  r_shift;
    logic [7:0]  r_tx_shift;
    logic [15:0] r_tx_word;
    logic        r_byte_sel;  // 0 = MSB byte, 1 = LSB byte
    logic        r_rw;
    logic        r_sda_oe;
    logic        r_busy;
    logic        r_wr_valid;
    logic        r_rd_done;
    logic [7:0]  r_wr_data;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_tx_byte;

    assign w_scl      = r_scl_sync[SYNC_STG-1];
    assign w_sda      = r_sda_sync[SYNC_STG-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high in both the previous and current sample so that an
    // SDA change coinciding with an SCL edge is never mistaken for START/STOP.
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_tx_byte  = r_byte_sel ? r_tx_word[7:0] : r_tx_word[15:8];

    assign bus.sda_oe = r_sda_oe;
    assign wr_data    = r_wr_data;
    assign wr_valid   = r_wr_valid;
    assign rd_done    = r_rd_done;
    assign busy       = r_busy;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STG-2:0], bus.scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STG-2:0], bus.sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_got8     <= 1'b0;
            r_shift    <= 8'h00;
            r_tx_shift <= 8'h00;
            r_tx_word  <= 16'h0000;
            r_byte_sel <= 1'b0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_rd_done  <= 1'b0;
            r_wr_data  <= 8'h00;
        end else begin
            r_wr_valid <= 1'b0;
            r_rd_done  <= 1'b0;

            if (w_stop) begin
                r_state   <= S_IDLE;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_got8    <= 1'b0;
            end else if (w_start) begin
                // START or repeated START: abandon whatever was in flight
                r_state   <= S_ADDR;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_got8    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end

                    // The SCL fall that follows START has r_got8=0 and is ignored
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_got8 <= 1'b1;
                        end else if (w_scl_fall && r_got8) begin
                            r_got8 <= 1'b0;
                            if (r_shift[7:1] == ADDR) begin
                                r_state    <= S_ADDR_ACK;
                                r_sda_oe   <= 1'b1;
                                r_busy     <= 1'b1;
                                r_tx_word  <= temp_in;
                                r_byte_sel <= 1'b0;
                                r_rw       <= r_shift[0];
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end

                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 3'd0;
                            if (r_rw) begin
                                r_state    <= S_TX;
                                r_sda_oe   <= ~w_tx_byte[7];
                                r_tx_shift <= {w_tx_byte[6:0], 1'b0};
                            end else begin
                                r_state  <= S_RX;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end

                    S_TX: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_got8 <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (r_got8) begin
                                r_got8   <= 1'b0;
                                r_sda_oe <= 1'b0;
                                r_state  <= S_TX_ACK;
                            end else begin
                                r_sda_oe   <= ~r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            end
                        end
                    end

                    // byte_sel flips on the ACK rise so the following fall
                    // already sees the next byte through w_tx_byte
                    S_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_rd_done <= 1'b1;
                                r_busy    <= 1'b0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_byte_sel <= ~r_byte_sel;
                            end
                        end else if (w_scl_fall) begin
                            r_state    <= S_TX;
                            r_bit_cnt  <= 3'd0;
                            r_sda_oe   <= ~w_tx_byte[7];
                            r_tx_shift <= {w_tx_byte[6:0], 1'b0};
                        end
                    end

                    S_RX: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_got8 <= 1'b1;
                        end else if (w_scl_fall && r_got8) begin
                            r_got8     <= 1'b0;
                            r_wr_data  <= r_shift;
                            r_wr_valid <= 1'b1;
                            r_sda_oe   <= 1'b1;
                            r_state    <= S_RX_ACK;
                        end
                    end

                    S_RX_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_RX;
                        end
                    end

                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_temp_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_temp_responder
//   Bit-banged I2C master driving the responder through its bus interface.
//   Expected read bytes come from a transaction-level model: the word seen at
//   address match, byte k of a read = MSB when k is even, LSB when odd.
// ---------------------------------------------------------------------------
module tb_i2c_temp_responder;
    localparam logic [6:0] TADDR = 7'h4B;
    localparam int         SSTG  = 2;
    localparam int         Q     = 10;   // quarter SCL period in clocks

    logic        clk;
    logic        rst_n;
    logic        m_scl;
    logic        m_sda;
    logic [15:0] temp_in;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        rd_done;
    logic        busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Monitor-owned observations
    logic [7:0] wr_q[$];
    int         rd_done_cnt = 0;
    int         oe_cnt      = 0;
    int         busy_cnt    = 0;

    i2c_temp_responder_if bus_if ();
    assign bus_if.scl_in = m_scl;
    assign bus_if.sda_in = m_sda & ~bus_if.sda_oe;   // open-drain wired-AND

    i2c_temp_responder #(.ADDR(TADDR), .SYNC_STG(SSTG)) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .bus        (bus_if.slave),
        .temp_in    (temp_in),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .rd_done    (rd_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) wr_q.push_back(wr_data);
        if (rd_done) rd_done_cnt = rd_done_cnt + 1;
        if (bus_if.sda_oe) oe_cnt = oe_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_rd_byte(input logic [15:0] snap, input int k);
        return (k % 2 == 0) ? snap[15:8] : snap[7:0];
    endfunction

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        m_sda = 1'b1; m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic m_rstart();
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic m_stop();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wq();
        m_scl = 1'b1; wq(); wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        b = bus_if.sda_in;
        wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    // Read of nbytes; temp_in is set to t_after once the address is ACKed,
    // which must not affect the bytes of this transfer. Ends without STOP.
    task automatic xfer_read(input string tag, input logic [6:0] a, input int nbytes,
                             input logic [15:0] t, input logic [15:0] t_after, input bit rep);
        logic       ack;
        logic [7:0] d;
        bit         hit;
        int         rd0;
        hit = (a == TADDR);
        temp_in = t;
        rd0 = rd_done_cnt;
        if (rep) m_rstart(); else m_start();
        write_byte({a, 1'b1}, ack);
        check({tag, " addr ack"}, ack, hit ? 1'b0 : 1'b1);
        if (hit) begin
            check({tag, " busy"}, busy, 1'b1);
            temp_in = t_after;
            for (int k = 0; k < nbytes; k++) begin
                read_byte(d, (k == nbytes - 1));
                check($sformatf("%s byte%0d", tag, k), d, model_rd_byte(t, k));
            end
        end
        check({tag, " rd_done"}, rd_done_cnt - rd0, hit ? 1 : 0);
        check({tag, " busy end"}, busy, 1'b0);
    endtask

    task automatic xfer_write(input string tag, input logic [6:0] a, input int nbytes,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic       ack;
        logic [7:0] d[3];
        bit         hit;
        int         q0;
        d[0] = d0; d[1] = d1; d[2] = d2;
        hit = (a == TADDR);
        q0 = wr_q.size();
        m_start();
        write_byte({a, 1'b0}, ack);
        check({tag, " addr ack"}, ack, hit ? 1'b0 : 1'b1);
        if (hit) begin
            for (int k = 0; k < nbytes; k++) begin
                write_byte(d[k], ack);
                check($sformatf("%s data ack%0d", tag, k), ack, 1'b0);
            end
        end
        m_stop();
        wq();
        check({tag, " wr count"}, wr_q.size() - q0, hit ? nbytes : 0);
        if (hit) begin
            for (int k = 0; k < nbytes; k++) begin
                if (q0 + k < wr_q.size())
                    check($sformatf("%s wr_data%0d", tag, k), wr_q[q0 + k], d[k]);
            end
        end
        check({tag, " busy end"}, busy, 1'b0);
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [6:0] a;
        int         oe0;
        int         bz0;
        int         q0;

        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; temp_in = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst sda_oe",   bus_if.sda_oe, 1'b0);
        check("rst busy",     busy, 1'b0);
        check("rst wr_valid", wr_valid, 1'b0);
        check("rst rd_done",  rd_done, 1'b0);
        check("rst wr_data",  wr_data, 8'h00);
        rst_n = 1'b1;
        wq();

        // Basic 2-byte read
        xfer_read("t1", TADDR, 2, 16'h1A80, 16'h1A80, 1'b0);
        m_stop(); wq();

        // Address mismatch: no ACK driven, busy never set
        oe0 = oe_cnt; bz0 = busy_cnt;
        m_start();
        write_byte({7'h48, 1'b1}, ack);
        check("t2 nack", ack, 1'b1);
        check("t2 oe cycles", oe_cnt - oe0, 0);
        check("t2 busy cycles", busy_cnt - bz0, 0);
        m_stop(); wq();

        // Two-byte write
        xfer_write("t3", TADDR, 2, 8'h03, 8'hC5, 8'h00);

        // Snapshot isolation, then repeated START picks up the new word
        xfer_read("t4a", TADDR, 2, 16'h1A80, 16'h2000, 1'b0);
        xfer_read("t4b", TADDR, 2, 16'h2000, 16'h2000, 1'b1);
        m_stop(); wq();

        // byte_sel wraps back to MSB
        xfer_read("t5", TADDR, 3, 16'h1A80, 16'h5555, 1'b0);
        m_stop(); wq();

        // STOP in the middle of a write byte
        q0 = wr_q.size();
        m_start();
        write_byte({TADDR, 1'b0}, ack);
        check("t6a addr ack", ack, 1'b0);
        for (int i = 0; i < 4; i++) write_bit(i[0]);
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1;
        repeat (SSTG + 2) @(negedge clk);
        check("t6a oe after stop", bus_if.sda_oe, 1'b0);
        check("t6a busy after stop", busy, 1'b0);
        wq();
        check("t6a no wr_valid", wr_q.size() - q0, 0);
        xfer_write("t6a next", TADDR, 1, 8'hA7, 8'h00, 8'h00);

        // Reset while transmitting a zero byte (target holding SDA low)
        temp_in = 16'h0000;
        m_start();
        write_byte({TADDR, 1'b1}, ack);
        check("t6b addr ack", ack, 1'b0);
        for (int i = 0; i < 3; i++) read_bit(b);
        check("t6b oe driving", bus_if.sda_oe, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6b oe reset", bus_if.sda_oe, 1'b0);
        check("t6b busy reset", busy, 1'b0);
        m_scl = 1'b1; m_sda = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wq();
        xfer_read("t6b next", TADDR, 2, 16'hBEEF, 16'h1234, 1'b0);
        m_stop(); wq();

        // Randomised transfers
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == TADDR) a = 7'h10;
            end else begin
                a = TADDR;
            end
            if ($urandom_range(0, 1) == 1) begin
                xfer_read($sformatf("r%0d rd", it), a, int'($urandom_range(1, 3)),
                          16'($urandom), 16'($urandom), 1'b0);
                m_stop(); wq();
            end else begin
                xfer_write($sformatf("r%0d wr", it), a, int'($urandom_range(1, 3)),
                           8'($urandom), 8'($urandom), 8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
